// File: rtl/mtr_pkg.sv
// Shared types and constants for the two-channel H-bridge PWM driver.
package mtr_pkg;

    localparam int PWM_W   = 11;
    localparam int SPD_W   = 12;
    localparam int PWM_MAX = (1 << PWM_W) - 1;

    typedef enum logic [1:0] {IDLE, FWD, REV, DEAD} chan_st_t;

    // |spd| clipped to the PWM range; the most negative code would otherwise overflow.
    function automatic logic [PWM_W-1:0] spd_to_mag(input logic [SPD_W-1:0] spd);
        logic [SPD_W-1:0] neg;
        neg = -spd;
        if (!spd[SPD_W-1])
            return spd[PWM_W-1:0];
        else if (spd == {1'b1, {(SPD_W-1){1'b0}}})
            return PWM_W'(PWM_MAX);
        else
            return neg[PWM_W-1:0];
    endfunction

endpackage

// File: rtl/mtr_drv_pwm_chan.sv
// One motor channel: period-boundary shadow registers, direction FSM with
// dead-period counter, and registered forward/reverse leg outputs.
module mtr_chan
    import mtr_pkg::*;
#(
    parameter int DEAD_PER = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_go,
    input  logic             i_boundary,
    input  logic [PWM_W-1:0] i_cnt,
    input  logic [SPD_W-1:0] i_spd,
    output logic             o_fwd,
    output logic             o_rev
);

    chan_st_t         r_st;
    logic             r_sign;
    logic [PWM_W-1:0] r_mag;
    logic [1:0]       r_dead;
    logic             r_fwd;
    logic             r_rev;

    logic             w_sign;
    logic [PWM_W-1:0] w_mag;
    logic             w_raw;
    chan_st_t         w_tgt;

    assign w_sign = i_spd[SPD_W-1];
    assign w_mag  = spd_to_mag(i_spd);
    assign w_raw  = (i_cnt < r_mag);
    assign w_tgt  = w_sign ? REV : FWD;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_st   <= IDLE;
            r_sign <= 1'b0;
            r_mag  <= '0;
            r_dead <= '0;
            r_fwd  <= 1'b0;
            r_rev  <= 1'b0;
        end else begin
            // Leg gating on the shadow sign keeps the two legs exclusive by construction.
            r_fwd <= i_go && (r_st == FWD) && !r_sign && w_raw;
            r_rev <= i_go && (r_st == REV) &&  r_sign && w_raw;
            if (i_boundary) begin
                r_sign <= w_sign;
                r_mag  <= w_mag;
            end
            if (!i_go) begin
                r_st   <= IDLE;
                r_dead <= '0;
            end else if (i_boundary) begin
                case (r_st)
                    IDLE: r_st <= w_tgt;
                    FWD: if (w_sign) begin
                        r_st   <= DEAD;
                        r_dead <= 2'(DEAD_PER);
                    end
                    REV: if (!w_sign) begin
                        r_st   <= DEAD;
                        r_dead <= 2'(DEAD_PER);
                    end
                    DEAD: if (r_dead <= 2'd1) begin
                        r_st   <= w_tgt;
                        r_dead <= '0;
                    end else begin
                        r_dead <= r_dead - 2'd1;
                    end
                    default: r_st <= IDLE;
                endcase
            end
        end
    end

    assign o_fwd = r_fwd;
    assign o_rev = r_rev;

endmodule

// File: rtl/mtr_drv_pwm.sv
// Two-channel H-bridge PWM driver fed by the PID speed interface; owns the
// shared period counter and period_strt pulse.
module mtr_drv_pwm
    import mtr_pkg::*;
#(
    parameter int DEAD_PER = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [SPD_W-1:0] lft_spd,
    input  logic [SPD_W-1:0] right_spd,
    output logic             lft_fwd,
    output logic             lft_rev,
    output logic             rgt_fwd,
    output logic             rgt_rev,
    output logic             period_strt
);

    logic [PWM_W-1:0] r_cnt;
    logic             r_period_strt;
    logic             w_boundary;
    logic             w_go;

    assign w_boundary = &r_cnt;
    assign w_go       = go;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_period_strt <= 1'b0;
        end else begin
            r_cnt         <= r_cnt + PWM_W'(1);
            r_period_strt <= (r_cnt == '0);
        end
    end

    assign period_strt = r_period_strt;

    mtr_chan #(.DEAD_PER(DEAD_PER)) u_lft (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_go       (w_go),
        .i_boundary (w_boundary),
        .i_cnt      (r_cnt),
        .i_spd      (lft_spd),
        .o_fwd      (lft_fwd),
        .o_rev      (lft_rev)
    );

    mtr_chan #(.DEAD_PER(DEAD_PER)) u_rgt (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_go       (w_go),
        .i_boundary (w_boundary),
        .i_cnt      (r_cnt),
        .i_spd      (right_spd),
        .o_fwd      (rgt_fwd),
        .o_rev      (rgt_rev)
    );

endmodule

// File: tb/tb_mtr_drv_pwm.sv
// Bench for mtr_drv_pwm: per-period pulse-count table, hand-written go/reset
// sequences, and randomized speeds checked cycle-by-cycle against a behavioural model.
module tb_mtr_drv_pwm;

    localparam int DEAD_PER = 1;
    localparam int PERIOD   = 2048;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        go = 1'b0;
    logic [11:0] lft_spd = '0;
    logic [11:0] right_spd = '0;
    logic        lft_fwd, lft_rev, rgt_fwd, rgt_rev, period_strt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mtr_drv_pwm #(.DEAD_PER(DEAD_PER)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .go          (go),
        .lft_spd     (lft_spd),
        .right_spd   (right_spd),
        .lft_fwd     (lft_fwd),
        .lft_rev     (lft_rev),
        .rgt_fwd     (rgt_fwd),
        .rgt_rev     (rgt_rev),
        .period_strt (period_strt)
    );

    // ---------------- behavioural reference model ----------------
    // Each channel is described by a drive direction (+1, -1, 0) and the
    // number of whole periods it still has to stay dead.
    int   m_cnt;
    int   m_drive[2];
    int   m_dead[2];
    int   m_mag[2];
    bit   m_valid = 1'b0;
    logic e_lf, e_lr, e_rf, e_rr, e_ps;
    bit   overlap_seen = 1'b0;

    function automatic int mag_of(input logic [11:0] s);
        int v;
        v = int'($signed(s));
        if (v < 0) v = -v;
        if (v > PERIOD - 1) v = PERIOD - 1;
        return v;
    endfunction

    function automatic int dir_of(input logic [11:0] s);
        return s[11] ? -1 : 1;
    endfunction

    always @(posedge clk) begin : mdl
        logic [11:0] s;
        int d;
        if (!rst_n) begin
            m_cnt = 0;
            for (int c = 0; c < 2; c++) begin
                m_drive[c] = 0; m_dead[c] = 0; m_mag[c] = 0;
            end
            {e_lf, e_lr, e_rf, e_rr, e_ps} = '0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            e_lf = go && (m_drive[0] ==  1) && (m_cnt < m_mag[0]);
            e_lr = go && (m_drive[0] == -1) && (m_cnt < m_mag[0]);
            e_rf = go && (m_drive[1] ==  1) && (m_cnt < m_mag[1]);
            e_rr = go && (m_drive[1] == -1) && (m_cnt < m_mag[1]);
            e_ps = (m_cnt == 0);
            for (int c = 0; c < 2; c++) begin
                s = (c == 0) ? lft_spd : right_spd;
                d = dir_of(s);
                if (m_cnt == PERIOD - 1) m_mag[c] = mag_of(s);
                if (!go) begin
                    m_drive[c] = 0;
                    m_dead[c]  = 0;
                end else if (m_cnt == PERIOD - 1) begin
                    if (m_dead[c] > 0) begin
                        m_dead[c] = m_dead[c] - 1;
                        if (m_dead[c] == 0) m_drive[c] = d;
                    end else if (m_drive[c] == 0) begin
                        m_drive[c] = d;
                    end else if (m_drive[c] != d) begin
                        m_drive[c] = 0;
                        m_dead[c]  = DEAD_PER;
                    end
                end
            end
            m_cnt = (m_cnt + 1) % PERIOD;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            n_tests++;
            if ({lft_fwd, lft_rev, rgt_fwd, rgt_rev, period_strt} !== {e_lf, e_lr, e_rf, e_rr, e_ps}) begin
                n_fail++;
                $display("FAIL model t=%0t: got lf/lr/rf/rr/ps=%b%b%b%b%b expected %b%b%b%b%b", $time,
                         lft_fwd, lft_rev, rgt_fwd, rgt_rev, period_strt, e_lf, e_lr, e_rf, e_rr, e_ps);
            end
            assert (!(lft_fwd && lft_rev) && !(rgt_fwd && rgt_rev)) else overlap_seen = 1'b1;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts high cycles of each leg over one output period starting at the next period_strt.
    task automatic measure(output int lf, output int lr, output int rf, output int rr, output int ps);
        int k;
        k = 0;
        lf = 0; lr = 0; rf = 0; rr = 0; ps = 0;
        while (!period_strt && k < 2 * PERIOD) begin
            @(negedge clk);
            k++;
        end
        if (!period_strt) begin
            n_tests++;
            n_fail++;
            $display("FAIL period_strt_timeout: got no pulse in %0d cycles expected one", k);
        end
        repeat (PERIOD) begin
            lf += int'(lft_fwd); lr += int'(lft_rev);
            rf += int'(rgt_fwd); rr += int'(rgt_rev);
            ps += int'(period_strt);
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic        go;
        logic [11:0] lft;
        logic [11:0] rgt;
        int          lf, lr, rf, rr;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int lf, lr, rf, rr, ps, d;

        // Inputs are applied at the start of a measured period; expectations
        // describe that period, which still runs on the previous period's samples.
        vecs[0] = '{1'b1, 12'h300, 12'h300,    0,   0,   0,    0};
        vecs[1] = '{1'b1, 12'h300, 12'h300,  768,   0, 768,    0};
        vecs[2] = '{1'b1, 12'h3FF, 12'h201,  768,   0, 768,    0};
        vecs[3] = '{1'b1, 12'h100, 12'h201, 1023,   0, 513,    0};
        vecs[4] = '{1'b1, 12'hF00, 12'h201,  256,   0, 513,    0};
        vecs[5] = '{1'b1, 12'hF00, 12'h800,    0,   0, 513,    0};
        vecs[6] = '{1'b1, 12'hF00, 12'h800,    0, 256,   0,    0};
        vecs[7] = '{1'b1, 12'hF00, 12'h000,    0, 256,   0, 2047};
        vecs[8] = '{1'b1, 12'hF00, 12'h000,    0, 256,   0,    0};
        vecs[9] = '{1'b1, 12'hF00, 12'h000,    0, 256,   0,    0};

        go = 1'b1; lft_spd = 12'h300; right_spd = 12'h300;
        tick(3);
        check("reset_outputs", int'({lft_fwd, lft_rev, rgt_fwd, rgt_rev, period_strt}), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            go = vecs[i].go; lft_spd = vecs[i].lft; right_spd = vecs[i].rgt;
            measure(lf, lr, rf, rr, ps);
            check($sformatf("vec%0d_lft_fwd", i), lf, vecs[i].lf);
            check($sformatf("vec%0d_lft_rev", i), lr, vecs[i].lr);
            check($sformatf("vec%0d_rgt_fwd", i), rf, vecs[i].rf);
            check($sformatf("vec%0d_rgt_rev", i), rr, vecs[i].rr);
            check($sformatf("vec%0d_period_strt_count", i), ps, 1);
        end

        // go dropped mid-pulse, then re-enabled with the opposite sign.
        tick(10);
        check("rev_mid_pulse", int'(lft_rev), 1);
        go = 1'b0;
        tick(1);
        check("go_low_outputs", int'({lft_fwd, lft_rev, rgt_fwd, rgt_rev}), 0);
        lft_spd = 12'h100;
        go = 1'b1;
        measure(lf, lr, rf, rr, ps);
        check("rego_lft_fwd", lf, 256);
        check("rego_lft_rev", lr, 0);
        check("rego_rgt", rf + rr, 0);

        // Reset pulse in the middle of a forward pulse.
        tick(5);
        check("pre_reset_pulse", int'(lft_fwd), 1);
        rst_n = 1'b0;
        tick(1);
        check("reset_mid_pulse", int'({lft_fwd, lft_rev, rgt_fwd, rgt_rev, period_strt}), 0);
        rst_n = 1'b1;
        tick(1);
        check("cnt_restart", int'(period_strt), 1);
        measure(lf, lr, rf, rr, ps);
        check("post_reset_idle", lf + lr + rf + rr, 0);
        measure(lf, lr, rf, rr, ps);
        check("post_reset_lft_fwd", lf, 256);

        // Randomized speeds and go glitches, checked by the model every cycle.
        for (int p = 0; p < 12; p++) begin
            d = $urandom_range(1, 1900);
            tick(d);
            case ($urandom_range(0, 7))
                0:       lft_spd = 12'h800;
                1:       lft_spd = 12'h000;
                2:       lft_spd = 12'h7FF;
                default: lft_spd = 12'($urandom);
            endcase
            right_spd = ($urandom_range(0, 7) == 0) ? 12'h800 : 12'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                go = 1'b0;
                tick($urandom_range(1, 40));
                go = 1'b1;
                d = d + 40;
            end
            tick(PERIOD + 100 - d);
        end

        check("no_leg_overlap", int'(overlap_seen), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mtr_drv_pwm.md
Name: mtr_drv_pwm

Overview:
- Consumer end of the PID speed interface. Takes signed 12-bit lft_spd/right_spd from the PID block and drives two H-bridge motor channels.
- Each channel gets a PWM output on its forward or reverse leg.
- Speed commands are double-buffered at PWM period boundaries.
- A dead period is inserted on every direction reversal. Sits between PID and the motor pins.

Parameters:
- PWM_W, 11, PWM counter width; period = 2^PWM_W cycles (2048).
- SPD_W, 12, speed input width, signed two's complement.
- DEAD_PER, 1, number of full PWM periods both legs held low on direction reversal (legal range 1..3).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- go  in  1  drive enable; low forces both channels to coast.
- lft_spd  in  12  left speed command, signed.
- right_spd  in  12  right speed command, signed.
- lft_fwd  out  1  left forward-leg PWM.
- lft_rev  out  1  left reverse-leg PWM.
- rgt_fwd  out  1  right forward-leg PWM.
- rgt_rev  out  1  right reverse-leg PWM.
- period_strt  out  1  one-cycle pulse marking the start of each PWM period.

Behaviour:
- Reset (rst_n low at a posedge):
  - cnt=0, all four PWM outputs=0, period_strt=0.
  - Shadow magnitude/sign=0, both channel FSMs in IDLE, dead counters=0.
  - Reset mid-pulse drops outputs at that same edge.
- Counter: cnt is PWM_W bits, free-running 0..2047, wraps to 0. It runs regardless of go.
- Sampling:
  - On the cycle cnt==2047, each channel captures sign = spd[11] and mag = |spd|.
  - -2048 saturates to 2047. Zero is treated as positive.
  - Inputs are ignored at all other times; mid-period changes take effect at the next period.
- Compare: pwm_raw = (cnt < mag).
  - Outputs are registered, so the active leg is high for exactly mag consecutive cycles, starting the cycle after cnt==0.
  - mag=0 gives a constant low; mag=2047 gives 2047 of 2048 cycles high.
- period_strt: registered from cnt==0, so it is high in the first cycle of each output period.
- Per-channel FSM (states IDLE, FWD, REV, DEAD); transitions occur only at the period boundary (cnt==2047 edge) unless noted:
  - IDLE: both legs low. At a boundary with go=1, go to FWD if sign=0, else REV. No dead period out of IDLE.
  - FWD: fwd leg = pwm_raw, rev=0. At a boundary, if the new sign=1, go to DEAD and load the dead counter with DEAD_PER.
  - REV: mirror of FWD.
  - DEAD: both legs low. Decrement at each boundary; at zero, enter FWD/REV per the latest sampled sign. A sign change during DEAD does not restart the dead counter.
  - Any state with go=0: go to IDLE at the next posedge (not boundary-gated), outputs low from that edge.
- fwd and rev of a channel are never high in the same cycle. The verification engineer checks this with an assertion.
- The two channels are fully independent apart from sharing cnt.

Decomposition:
- Package mtr_pkg holds:
  - typedef enum chan_st_t {IDLE, FWD, REV, DEAD};
  - localparams PWM_W, SPD_W, PWM_MAX = 2^PWM_W-1.
- Sub-module mtr_chan: one channel's shadow registers, abs/saturate, FSM, dead counter and output flops. It is instantiated twice.
- Top holds cnt, period_strt and the go fan-out.

Test Plan:
1. Reset, go=1, lft=right=0x300 → first period after IDLE exit: lft_fwd and rgt_fwd each high 768 cycles per 2048; rev legs 0; period_strt every 2048 cycles.
2. lft=0x3FF, right=0x201 → lft_fwd high 1023 cycles, rgt_fwd high 513 cycles per period; change applied only from the next period_strt.
3. lft 0x100 → 0xF00 (-256) mid-period → current period keeps 256-cycle fwd pulse; next 2048 cycles lft_fwd=lft_rev=0; then lft_rev high 256 cycles per period. Right channel is unaffected.
4. right=0x800 → rgt_rev high 2047 of 2048 cycles. right=0x000 → all right legs 0, FSM FWD.
5. go dropped mid-pulse → all legs 0 at next posedge. go raised with opposite sign → resumes at next period with the new direction and no dead period.
6. rst_n low for one cycle mid-pulse → outputs 0 at that edge, cnt restarts at 0. The no-overlap assertion holds throughout all scenarios.
